tetris_move_driver: RTL and testbench
=====================================

# tetris_move_driver

Synthesizable stimulus-side counterpart of the tetris block: buffers a round of 16 moves (tetromino, position), issues them one at a time on the `in_valid` / `tetrominoes` / `position` interface, and waits for each `score_valid` response. It ends a round early on `fail`, discards the unused moves, and reports score, final board, latency and protocol violations. It sits between a move source (host, ROM or LFSR) and the tetris core on FPGA and emulation builds.

## Interface
- `DEPTH`, 16: move FIFO depth; also moves per round.
- `TIMEOUT`, 1000: maximum latency cycles per move before abort.
- `LAT_W`, 16: width of the accumulated latency counter.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `load_valid` in 1: push request for the move FIFO.
- `load_tetromino` in 3: tetromino to push.
- `load_position` in 3: position to push.
- `load_ready` out 1: high when FIFO count < DEPTH.
- `round_start` in 1: single-cycle request to run one round.
- `gap` in 2: idle cycles between a response and the next issue; sampled at round start.
- `in_valid` out 1: move strobe to the core.
- `tetrominoes` out 3: move tetromino.
- `position` out 3: move position.
- `score_valid` in 1, `fail` in 1, `score` in 4, `tetris_valid` in 1, `tetris` in 72: core responses.
- `round_done` out 1: one-cycle end-of-round pulse.
- `round_fail` out 1: round ended by fail or by timeout.
- `final_score` out 4: last score received.
- `final_tetris` out 72: last board captured.
- `moves_issued` out 5: moves issued in the current or last round.
- `total_latency` out LAT_W: summed latency, saturating.
- `timeout_err` out 1: sticky.
- `proto_err` out 1: sticky.

## Operation
- All outputs reset to 0, the FIFO is empty and the FSM is in IDLE.
- **FSM states:** IDLE, ISSUE, WAIT, GAP, DRAIN, DONE.
- **IDLE:**
  - `round_start` is accepted only when FIFO count == DEPTH; otherwise it is ignored.
  - On accept: clear `moves_issued`, `round_fail`, `final_score`, `final_tetris` and `total_latency`; latch `gap`; go to ISSUE.
- **ISSUE:**
  - One cycle with `in_valid`=1, carrying the FIFO head.
  - Pop the head, increment `moves_issued`, go to WAIT.
- **WAIT:**
  - The latency counter starts at 1 in the cycle after ISSUE and increments each cycle.
  - On `score_valid`=1: add the latency to `total_latency`, capture `score` into `final_score`, and capture `tetris` into `final_tetris` if `tetris_valid`.
  - Next state after `score_valid`:
    - if `fail`, set `round_fail` and go to DRAIN;
    - else if `moves_issued`==DEPTH, go to DONE;
    - else if the latched gap > 0, go to GAP;
    - else go to ISSUE.
  - If the latency reaches TIMEOUT without `score_valid`: set `timeout_err` and `round_fail`, go to DRAIN.
- **GAP:** wait the latched number of cycles (0–3), then go to ISSUE.
- **DRAIN:** pop one entry per cycle until DEPTH−`moves_issued` entries are discarded; nothing is driven. Then go to DONE.
- **DONE:** `round_done`=1 for one cycle, then IDLE.
- **Outputs:** `tetrominoes` / `position` are 0 whenever `in_valid`=0.
- **Loading:** loading may continue during a round for the next round. A push and pop in the same cycle leaves the count unchanged. A push while full is dropped.
- **`proto_err` is set on any of:**
  - `score_valid` high outside WAIT;
  - `score_valid` high two consecutive cycles;
  - `score_valid`=0 with `score`, `fail` or `tetris_valid` nonzero;
  - `tetris_valid`=0 with `tetris` nonzero.
- **Saturation:** `total_latency` saturates at all-ones.
- **Reset mid-round:** returns to IDLE and empties the FIFO; sticky flags clear only on `rst`.

## Timing
- `load_ready` is combinational from the count; a push completes on the same edge.
- Issue latency: `round_start` sampled on edge N → `in_valid` high in cycle N+1.
- A response in the first WAIT cycle counts as latency 1. Next `in_valid` comes at least gap+1 cycles after `score_valid`.
- Fail on move k: DRAIN lasts DEPTH−k cycles, then `round_done`.

## Structure
- **`tetris_pkg`:**
  - `move_t` struct (tetromino[2:0], position[2:0]);
  - FSM state enum;
  - constants `MOVES_PER_ROUND`=16, `ROWS`=12, `COLS`=6, `BOARD_W`=72.
- **Sub-module `move_fifo`:** synchronous FIFO of `move_t`, depth DEPTH, with count output. The FSM and counters stay in the top.

## Test plan
- **Full round:** load 16 moves, `round_start`, gap=0, responder answers after 2 cycles each → 16 `in_valid` pulses, `round_done` 1 cycle after the 16th `score_valid`, `total_latency`=32, `round_fail`=0.
- **Early fail:** `fail`=1 on move 5, `score`=3 → `round_fail`=1, `final_score`=3, `moves_issued`=5, 11 DRAIN cycles, FIFO count 0 at `round_done`.
- **Gap spacing:** gap=3 → exactly 3 idle cycles between each `score_valid` and the next `in_valid`.
- **Timeout:** responder silent → `timeout_err`=1 after 1000 WAIT cycles, `round_done` after the drain.
- **Protocol errors:** `score_valid` held 2 cycles, or `tetris`=1 while `tetris_valid`=0 → `proto_err`=1, still set after `round_done`.
- **Start gating and overlap:** `round_start` with 15 moves loaded is ignored; loading 16 more during a round, pushing only while `load_ready` is high → the next round starts immediately when requested.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared types and board constants for the tetris core and its move driver.
package tetris_pkg;

    localparam int unsigned MOVES_PER_ROUND = 16;
    localparam int unsigned ROWS            = 12;
    localparam int unsigned COLS            = 6;
    localparam int unsigned BOARD_W         = ROWS * COLS;

    typedef struct packed {
        logic [2:0] tetromino;
        logic [2:0] position;
    } move_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/move_fifo.sv
// Synchronous FIFO of moves with an occupancy count; pushes while full are dropped.
module move_fifo
    import tetris_pkg::*;
#(
    parameter int unsigned DEPTH = MOVES_PER_ROUND,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  move_t            push_data,
    input  logic             pop,
    output move_t            head,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    move_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tetris_move_driver.sv
// Buffers a round of moves, issues them to the tetris core one at a time and
// collects score, board, latency and protocol status for the round.
module tetris_move_driver
    import tetris_pkg::*;
#(
    parameter int unsigned DEPTH   = MOVES_PER_ROUND,
    parameter int unsigned TIMEOUT = 1000,
    parameter int unsigned LAT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_valid,
    input  logic [2:0]         load_tetromino,
    input  logic [2:0]         load_position,
    output logic               load_ready,
    input  logic               round_start,
    input  logic [1:0]         gap,
    output logic               in_valid,
    output logic [2:0]         tetrominoes,
    output logic [2:0]         position,
    input  logic               score_valid,
    input  logic               fail,
    input  logic [3:0]         score,
    input  logic               tetris_valid,
    input  logic [BOARD_W-1:0] tetris,
    output logic               round_done,
    output logic               round_fail,
    output logic [3:0]         final_score,
    output logic [BOARD_W-1:0] final_tetris,
    output logic [4:0]         moves_issued,
    output logic [LAT_W-1:0]   total_latency,
    output logic               timeout_err,
    output logic               proto_err
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    state_t           state;
    move_t            head;
    move_t            push_move;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic [TMO_W-1:0] lat;
    logic [1:0]       gap_lat;
    logic [1:0]       gap_cnt;
    logic [4:0]       drain_left;
    logic             sv_q;
    logic             timed_out;
    logic             abort;
    logic             last_move;
    logic             proto_hit;

    assign load_ready = count < CNT_W'(DEPTH);
    assign push       = load_valid && load_ready;
    assign push_move  = {load_tetromino, load_position};
    assign pop        = (state == ST_ISSUE) || (state == ST_DRAIN);

    assign timed_out  = !score_valid && (lat == TMO_W'(TIMEOUT));
    assign abort      = (score_valid && fail) || timed_out;
    assign last_move  = moves_issued == 5'(DEPTH);

    assign proto_hit  = (score_valid && (state != ST_WAIT))
                     || (score_valid && sv_q)
                     || (!score_valid && ((score != '0) || fail || tetris_valid))
                     || (!tetris_valid && (tetris != '0));

    move_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_move),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    function automatic logic [LAT_W-1:0] sat_add(input logic [LAT_W-1:0] a,
                                                 input logic [TMO_W-1:0] b);
        logic [LAT_W:0] sum;
        sum = {1'b0, a} + (LAT_W + 1)'(b);
        return sum[LAT_W] ? '1 : sum[LAT_W-1:0];
    endfunction

    // Round sequencer; the move bus is registered and idles at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            in_valid      <= 1'b0;
            tetrominoes   <= '0;
            position      <= '0;
            round_done    <= 1'b0;
            round_fail    <= 1'b0;
            final_score   <= '0;
            final_tetris  <= '0;
            moves_issued  <= '0;
            total_latency <= '0;
            timeout_err   <= 1'b0;
            lat           <= '0;
            gap_lat       <= '0;
            gap_cnt       <= '0;
            drain_left    <= '0;
        end else begin
            in_valid    <= 1'b0;
            tetrominoes <= '0;
            position    <= '0;
            round_done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (round_start && (count == CNT_W'(DEPTH))) begin
                        moves_issued  <= '0;
                        round_fail    <= 1'b0;
                        final_score   <= '0;
                        final_tetris  <= '0;
                        total_latency <= '0;
                        gap_lat       <= gap;
                        in_valid      <= 1'b1;
                        tetrominoes   <= head.tetromino;
                        position      <= head.position;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    moves_issued <= moves_issued + 5'd1;
                    lat          <= TMO_W'(1);
                    state        <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (score_valid) begin
                        total_latency <= sat_add(total_latency, lat);
                        final_score   <= score;
                        if (tetris_valid) begin
                            final_tetris <= tetris;
                        end
                    end
                    if (timed_out) begin
                        timeout_err <= 1'b1;
                    end
                    if (abort) begin
                        round_fail <= 1'b1;
                        if (last_move) begin
                            round_done <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            drain_left <= 5'(DEPTH) - moves_issued;
                            state      <= ST_DRAIN;
                        end
                    end else if (score_valid) begin
                        if (last_move) begin
                            round_done <= 1'b1;
                            state      <= ST_DONE;
                        end else if (gap_lat != '0) begin
                            gap_cnt <= gap_lat - 2'd1;
                            state   <= ST_GAP;
                        end else begin
                            in_valid    <= 1'b1;
                            tetrominoes <= head.tetromino;
                            position    <= head.position;
                            state       <= ST_ISSUE;
                        end
                    end else begin
                        lat <= lat + TMO_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        in_valid    <= 1'b1;
                        tetrominoes <= head.tetromino;
                        position    <= head.position;
                        state       <= ST_ISSUE;
                    end else begin
                        gap_cnt <= gap_cnt - 2'd1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_left == 5'd1) begin
                        round_done <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        drain_left <= drain_left - 5'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky protocol monitor on the response interface.
    always_ff @(posedge clk) begin
        if (rst) begin
            sv_q      <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            sv_q <= score_valid;
            if (proto_hit) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tetris_move_driver.sv
// Directed bench for tetris_move_driver: full, failing, gapped, timed-out and
// protocol-violating rounds against a scripted responder.
module tb_tetris_move_driver;

    logic        clk;
    logic        rst;
    logic        load_valid;
    logic [2:0]  load_tetromino;
    logic [2:0]  load_position;
    logic        load_ready;
    logic        round_start;
    logic [1:0]  gap;
    logic        in_valid;
    logic [2:0]  tetrominoes;
    logic [2:0]  position;
    logic        score_valid;
    logic        fail;
    logic [3:0]  score;
    logic        tetris_valid;
    logic [71:0] tetris;
    logic        round_done;
    logic        round_fail;
    logic [3:0]  final_score;
    logic [71:0] final_tetris;
    logic [4:0]  moves_issued;
    logic [15:0] total_latency;
    logic        timeout_err;
    logic        proto_err;

    int n_checks = 0;
    int n_fails  = 0;
    logic [5:0] exp_q[$];

    tetris_move_driver dut (
        .clk            (clk),
        .rst            (rst),
        .load_valid     (load_valid),
        .load_tetromino (load_tetromino),
        .load_position  (load_position),
        .load_ready     (load_ready),
        .round_start    (round_start),
        .gap            (gap),
        .in_valid       (in_valid),
        .tetrominoes    (tetrominoes),
        .position       (position),
        .score_valid    (score_valid),
        .fail           (fail),
        .score          (score),
        .tetris_valid   (tetris_valid),
        .tetris         (tetris),
        .round_done     (round_done),
        .round_fail     (round_fail),
        .final_score    (final_score),
        .final_tetris   (final_tetris),
        .moves_issued   (moves_issued),
        .total_latency  (total_latency),
        .timeout_err    (timeout_err),
        .proto_err      (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Push n moves; either every cycle (extra pushes dropped) or only while ready.
    task automatic load_moves(input int n, input int base, input bit wait_ready, output int acc);
        int tries;
        tries = 0;
        acc   = 0;
        while (acc < n && tries < 400) begin
            load_valid     = wait_ready ? load_ready : 1'b1;
            load_tetromino = 3'(base + acc);
            load_position  = 3'((base + acc) * 3 + 1);
            if (load_valid && load_ready) begin
                exp_q.push_back({load_tetromino, load_position});
                acc++;
            end
            tick();
            tries++;
            if (!wait_ready && tries >= n) break;
        end
        load_valid = 1'b0;
    endtask

    // Starts a round and answers each move dly cycles after its in_valid.
    task automatic run_round(input logic [1:0] g_in, input int dly, input int fail_at,
                             input int silent_at, input bit hold_first,
                             output int pulses, output int last_iv, output int last_sv,
                             output int done_at);
        int   since_iv;
        bit   pend;
        bit   hold;
        logic [5:0] expv;
        pulses   = 0;
        last_iv  = -1;
        last_sv  = -1;
        done_at  = -1;
        since_iv = 0;
        pend     = 1'b0;
        hold     = 1'b0;
        gap         = g_in;
        round_start = 1'b1;
        tick();
        round_start = 1'b0;
        gap         = 2'd0;
        check("issue_lat", 72'(in_valid), 72'(1));
        for (int cyc = 0; cyc < 3000; cyc++) begin
            score_valid  = 1'b0;
            fail         = 1'b0;
            score        = 4'd0;
            tetris_valid = 1'b0;
            tetris       = '0;
            if (hold) begin
                score_valid = 1'b1;
                score       = 4'd9;
                hold        = 1'b0;
            end
            if (round_done) begin
                done_at = cyc;
                break;
            end
            if (in_valid) begin
                pulses++;
                last_iv  = cyc;
                since_iv = 0;
                pend     = (pulses != silent_at);
                if (last_sv >= 0) check("gap_idle", 72'(cyc - last_sv - 1), 72'(g_in));
                if (exp_q.size() == 0) begin
                    check("move_q_empty", 72'(0), 72'(1));
                end else begin
                    expv = exp_q.pop_front();
                    check("move", 72'({tetrominoes, position}), 72'(expv));
                end
            end else begin
                check("idle_bus", 72'({tetrominoes, position}), 72'(0));
                if (pend) begin
                    since_iv++;
                    if (since_iv == dly) begin
                        score_valid  = 1'b1;
                        fail         = (pulses == fail_at);
                        score        = (pulses == fail_at) ? 4'd3 : 4'(17 - pulses);
                        tetris_valid = 1'b1;
                        tetris       = {9{8'(pulses)}};
                        pend         = 1'b0;
                        last_sv      = cyc;
                        if (hold_first && pulses == 1) hold = 1'b1;
                    end
                end
            end
            tick();
        end
        score_valid  = 1'b0;
        fail         = 1'b0;
        score        = 4'd0;
        tetris_valid = 1'b0;
        tetris       = '0;
        if (done_at < 0) check("round_done_seen", 72'(0), 72'(1));
    endtask

    initial begin
        int acc;
        int pulses;
        int last_iv;
        int last_sv;
        int done_at;
        rst            = 1'b1;
        load_valid     = 1'b0;
        load_tetromino = 3'd0;
        load_position  = 3'd0;
        round_start    = 1'b0;
        gap            = 2'd0;
        score_valid    = 1'b0;
        fail           = 1'b0;
        score          = 4'd0;
        tetris_valid   = 1'b0;
        tetris         = '0;
        do_reset();

        check("rst_in_valid", 72'(in_valid), 72'(0));
        check("rst_bus", 72'({tetrominoes, position}), 72'(0));
        check("rst_round_done", 72'(round_done), 72'(0));
        check("rst_round_fail", 72'(round_fail), 72'(0));
        check("rst_final_score", 72'(final_score), 72'(0));
        check("rst_final_tetris", final_tetris, 72'(0));
        check("rst_moves_issued", 72'(moves_issued), 72'(0));
        check("rst_total_latency", 72'(total_latency), 72'(0));
        check("rst_timeout_err", 72'(timeout_err), 72'(0));
        check("rst_proto_err", 72'(proto_err), 72'(0));
        check("rst_load_ready", 72'(load_ready), 72'(1));

        // Start is ignored with only 15 moves buffered.
        load_moves(15, 0, 1'b0, acc);
        check("load15_acc", 72'(acc), 72'(15));
        round_start = 1'b1;
        tick();
        round_start = 1'b0;
        check("start_gated", 72'(in_valid), 72'(0));
        tick();
        check("start_gated2", 72'(in_valid), 72'(0));
        load_moves(1, 15, 1'b0, acc);
        check("full_ready", 72'(load_ready), 72'(0));

        // Full round, responses after 2 cycles, next round loaded alongside.
        fork
            load_moves(16, 8, 1'b1, acc);
            run_round(2'd0, 2, 0, 0, 1'b0, pulses, last_iv, last_sv, done_at);
        join
        check("full_pulses", 72'(pulses), 72'(16));
        check("full_done_lat", 72'(done_at - last_sv), 72'(1));
        check("full_total_lat", 72'(total_latency), 72'(32));
        check("full_round_fail", 72'(round_fail), 72'(0));
        check("full_moves", 72'(moves_issued), 72'(16));
        check("full_score", 72'(final_score), 72'(1));
        check("full_tetris", final_tetris, {9{8'h10}});
        check("overlap_acc", 72'(acc), 72'(16));
        check("overlap_full", 72'(load_ready), 72'(0));
        tick();
        check("done_one_cycle", 72'(round_done), 72'(0));

        // Early fail on move 5, overlapped round starts straight away.
        run_round(2'd0, 2, 5, 0, 1'b0, pulses, last_iv, last_sv, done_at);
        check("fail_pulses", 72'(pulses), 72'(5));
        check("fail_round_fail", 72'(round_fail), 72'(1));
        check("fail_score", 72'(final_score), 72'(3));
        check("fail_moves", 72'(moves_issued), 72'(5));
        check("fail_drain_len", 72'(done_at - last_sv), 72'(12));
        check("fail_total_lat", 72'(total_latency), 72'(10));
        check("fail_tetris", final_tetris, {9{8'h05}});
        check("fail_timeout_err", 72'(timeout_err), 72'(0));
        for (int i = 0; i < 11; i++) void'(exp_q.pop_front());
        load_moves(16, 3, 1'b0, acc);
        check("drained_acc", 72'(acc), 72'(16));
        check("drained_full", 72'(load_ready), 72'(0));

        // Gap of 3 idle cycles between each response and the next move.
        run_round(2'd3, 1, 0, 0, 1'b0, pulses, last_iv, last_sv, done_at);
        check("gap_pulses", 72'(pulses), 72'(16));
        check("gap_total_lat", 72'(total_latency), 72'(16));
        check("gap_round_fail", 72'(round_fail), 72'(0));
        check("gap_score", 72'(final_score), 72'(1));
        check("gap_done_lat", 72'(done_at - last_sv), 72'(1));

        // Silent responder: abort after 1000 WAIT cycles, then drain 15.
        load_moves(16, 5, 1'b0, acc);
        check("tmo_load_acc", 72'(acc), 72'(16));
        run_round(2'd0, 2, 0, 1, 1'b0, pulses, last_iv, last_sv, done_at);
        check("tmo_pulses", 72'(pulses), 72'(1));
        check("tmo_err", 72'(timeout_err), 72'(1));
        check("tmo_round_fail", 72'(round_fail), 72'(1));
        check("tmo_done_lat", 72'(done_at - last_iv), 72'(1016));
        check("tmo_total_lat", 72'(total_latency), 72'(0));
        check("tmo_moves", 72'(moves_issued), 72'(1));
        check("tmo_proto_clean", 72'(proto_err), 72'(0));
        for (int i = 0; i < 15; i++) void'(exp_q.pop_front());

        // Board bits without tetris_valid.
        tetris = 72'(1);
        tick();
        tetris = '0;
        check("proto_board", 72'(proto_err), 72'(1));
        tick();
        check("proto_sticky", 72'(proto_err), 72'(1));

        do_reset();
        check("rst_clears_proto", 72'(proto_err), 72'(0));
        check("rst_clears_tmo", 72'(timeout_err), 72'(0));
        check("rst_empties_fifo", 72'(load_ready), 72'(1));

        // score_valid held two cycles on the first move.
        load_moves(16, 2, 1'b0, acc);
        run_round(2'd0, 2, 0, 0, 1'b1, pulses, last_iv, last_sv, done_at);
        check("hold_pulses", 72'(pulses), 72'(16));
        check("hold_proto_err", 72'(proto_err), 72'(1));
        check("hold_total_lat", 72'(total_latency), 72'(32));
        tick();
        check("hold_proto_after", 72'(proto_err), 72'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
